// File: rtl/pcileech_com_pkg.sv
// Shared types and width helpers for the COM RX packer and its FIFO.
package pcileech_com_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_INIT,
    ST_RUN
  } state_e;

  localparam logic [31:0] RESYNC_PAT_DEFAULT = 32'h66665555;

  // Bits needed to count 0..n-1 (never less than one).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value n itself.
  function automatic int val_w(input int n);
    return cnt_w(n + 1);
  endfunction

endpackage

// File: rtl/pcileech_com_rx_fifo.sv
// Synchronous show-ahead FIFO; rdata_o always shows the head entry.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module pcileech_com_rx_fifo
  import pcileech_com_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = val_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // decide which entries are valid, and a reset mux on every bit is waste.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/pcileech_com_rx_packer.sv
// Packs RATIO transport words into one command word, honours host resync,
// emits boot words first. Optional counters: PCILEECH_COM_RX_STATS_EN.
module pcileech_com_rx_packer
  import pcileech_com_pkg::*;
#(
  parameter int              IN_W       = 32,
  parameter int              RATIO      = 2,
  parameter int              DEPTH      = 16,
  parameter int              INIT_N     = 5,
  parameter int              INIT_DELAY = 16,
  parameter logic [IN_W-1:0] RESYNC_PAT = IN_W'(RESYNC_PAT_DEFAULT),
  localparam int             OUT_W      = IN_W * RATIO,
  localparam int             INIT_BITS  = ((INIT_N > 0) ? INIT_N : 1) * OUT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INIT_BITS-1:0] init_data,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef PCILEECH_COM_RX_STATS_EN
  output logic [31:0]          stat_words,
  output logic [15:0]          stat_resync,
  output logic [15:0]          stat_drop,
`endif
  output logic                 overflow,
  output logic                 busy_init
);

  localparam int ACC_W  = OUT_W - IN_W;
  localparam int LANE_W = cnt_w(RATIO);
  localparam int DLY_W  = val_w(INIT_DELAY);
  localparam int IDX_W  = val_w(INIT_N);
  localparam int DLY_LAST = (INIT_DELAY > 0) ? INIT_DELAY - 1 : 0;

  state_e            state_q;
  logic [DLY_W-1:0]  dly_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic              resync, complete, pop, push, drop;
  logic [OUT_W-1:0]  pack_word, fifo_rdata;
  logic              fifo_full, fifo_empty;

  // Resync needs two consecutive patterns; the earlier one sits in the low lane.
  assign resync    = in_valid && (in_data == RESYNC_PAT) && (acc_q[IN_W-1:0] == RESYNC_PAT);
  assign complete  = in_valid && !resync && (lane_q == LANE_W'(RATIO - 1));
  assign pack_word = {acc_q, in_data};
  assign pop       = (state_q == ST_RUN) && out_ready && !fifo_empty;
  assign drop      = complete && fifo_full && !pop;
  assign push      = complete && !drop;

  // NOTE: next-state logic is combinational with blocking assignments and a
  // default for every target first, so no latch can be inferred.
  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q | drop;
    if (resync) begin
      lane_d = '0;
    end else if (in_valid) begin
      acc_d  = ACC_W'({acc_q, in_data});
      lane_d = complete ? '0 : lane_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT;
      dly_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (dly_q >= DLY_W'(DLY_LAST)) state_q <= (INIT_N == 0) ? ST_RUN : ST_INIT;
          else                           dly_q   <= dly_q + 1'b1;
        end
        ST_INIT: begin
          if (out_ready) begin
            if (idx_q == IDX_W'(INIT_N - 1)) state_q <= ST_RUN;
            else                             idx_q   <= idx_q + 1'b1;
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  // The output mux only switches source; the FIFO holds its head while stalled.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    case (state_q)
      ST_INIT: begin
        out_data  = init_data[idx_q*OUT_W +: OUT_W];
        out_valid = 1'b1;
      end
      ST_RUN: begin
        out_data  = fifo_rdata;
        out_valid = !fifo_empty;
      end
      default: ;
    endcase
  end

  assign overflow  = ovf_q;
  assign busy_init = (state_q != ST_RUN);

  pcileech_com_rx_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (pack_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef PCILEECH_COM_RX_STATS_EN
  logic [31:0] words_q;
  logic [15:0] resync_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q  <= '0;
      resync_q <= '0;
      drop_q   <= '0;
    end else begin
      if (push   && !(&words_q))  words_q  <= words_q + 1'b1;
      if (resync && !(&resync_q)) resync_q <= resync_q + 1'b1;
      if (drop   && !(&drop_q))   drop_q   <= drop_q + 1'b1;
    end
  end

  assign stat_words  = words_q;
  assign stat_resync = resync_q;
  assign stat_drop   = drop_q;
`endif

endmodule
